// File: rtl/la_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_core
// Purpose  : On-chip logic-analyser capture engine. Samples a probe bus into a
//            circular buffer with decimation, a pre-trigger window and a
//            masked level/rising-edge pattern trigger (plus force trigger),
//            then reads the buffer back oldest-first over an address port.
// Revision : 1.0 - initial release
// ============================================================================
module la_capture_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEC_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_trig_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic              trig_edge_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [DEC_W-1:0]  decim_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Capture pointers and counters
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q,   pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q,  post_cnt_d;
  logic [ADDR_W-1:0] trig_ptr_q,  trig_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [DEC_W-1:0]  div_cnt_q,   div_cnt_d;

  // Configuration latched at arm time
  logic [ADDR_W-1:0] pretrig_q,   pretrig_d;
  logic [DEC_W-1:0]  decim_q,     decim_d;
  logic [DATA_W-1:0] mask_q,      mask_d;
  logic [DATA_W-1:0] value_q,     value_d;
  logic              edge_q,      edge_d;

  // Status
  logic              match_prev_q, match_prev_d;
  logic              triggered_q,  triggered_d;
  logic              done_q,       done_d;

  // Sample buffer and registered read port
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Combinational helpers
  logic              busy;
  logic              strobe;
  logic              match;
  logic              trig_event;
  logic [ADDR_W-1:0] pre_cnt_inc;
  logic [ADDR_W-1:0] rd_ptr;

  // Strobe, match and trigger qualification for the current cycle
  always_comb begin
    busy        = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    strobe      = busy && (div_cnt_q == '0);
    match       = ((probe_i ^ value_q) & mask_q) == '0;
    trig_event  = strobe && (state_q == ST_ARMED) &&
                  (force_trig_i || (edge_q ? (match && !match_prev_q) : match));
    pre_cnt_inc = pre_cnt_q + ADDR_W'(1);
    rd_ptr      = start_ptr_q + rd_addr_i;
  end

  // Next-state logic: capture sequencing, counters and configuration latching
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_ptr_d   = trig_ptr_q;
    start_ptr_d  = start_ptr_q;
    div_cnt_d    = div_cnt_q;
    pretrig_d    = pretrig_q;
    decim_d      = decim_q;
    mask_d       = mask_q;
    value_d      = value_q;
    edge_d       = edge_q;
    match_prev_d = match_prev_q;
    triggered_d  = triggered_q;
    done_d       = done_q;

    // Decimation divider runs only while capturing
    if (busy) begin
      div_cnt_d = (div_cnt_q == '0) ? decim_q : (div_cnt_q - DEC_W'(1));
    end

    // Every strobe while capturing writes one sample
    if (strobe) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    // Edge detection history follows sampled match in PRE and ARMED
    if (strobe && ((state_q == ST_PRE) || (state_q == ST_ARMED))) begin
      match_prev_d = match;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          pretrig_d    = pretrig_i;
          decim_d      = decim_i;
          mask_d       = trig_mask_i;
          value_d      = trig_value_i;
          edge_d       = trig_edge_i;
          // Divider preloads with the new divisor, so decim=0 strobes on
          // the very next cycle
          div_cnt_d    = decim_i;
          wr_ptr_d     = '0;
          pre_cnt_d    = '0;
          match_prev_d = 1'b0;
          triggered_d  = 1'b0;
          done_d       = 1'b0;
          state_d      = (pretrig_i == '0) ? ST_ARMED : ST_PRE;
        end
      end

      ST_PRE: begin
        // Triggers are ignored here; leave once pretrig samples are stored
        if (strobe) begin
          pre_cnt_d = pre_cnt_inc;
          if (pre_cnt_inc == pretrig_q) begin
            state_d = ST_ARMED;
          end
        end
      end

      ST_ARMED: begin
        if (trig_event) begin
          trig_ptr_d  = wr_ptr_q;
          triggered_d = 1'b1;
          // DEPTH-1-pretrig equals the bitwise inverse within ADDR_W bits
          post_cnt_d  = ~pretrig_q;
          if (pretrig_q == {ADDR_W{1'b1}}) begin
            start_ptr_d = wr_ptr_q - pretrig_q;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d     = ST_POST;
          end
        end
      end

      ST_POST: begin
        if (strobe) begin
          post_cnt_d = post_cnt_q - ADDR_W'(1);
          if (post_cnt_q == ADDR_W'(1)) begin
            start_ptr_d = trig_ptr_q - pretrig_q;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous arm
    if (abort_i) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  // Control state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_ptr_q   <= '0;
      start_ptr_q  <= '0;
      div_cnt_q    <= '0;
      pretrig_q    <= '0;
      decim_q      <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      edge_q       <= 1'b0;
      match_prev_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_ptr_q   <= trig_ptr_d;
      start_ptr_q  <= start_ptr_d;
      div_cnt_q    <= div_cnt_d;
      pretrig_q    <= pretrig_d;
      decim_q      <= decim_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      edge_q       <= edge_d;
      match_prev_q <= match_prev_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
    end
  end

  // Sample buffer write port; contents deliberately unreset so it maps to block RAM
  always_ff @(posedge clk_i) begin
    if (strobe) begin
      mem[wr_ptr_q] <= probe_i;
    end
  end

  // Registered chronological read port; holds its value outside DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (state_q == ST_DONE) begin
      rd_data_q <= mem[rd_ptr];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign busy_o      = busy;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire
